// File: rtl/cpu_pkg.sv
// Shared constants for the instruction sequencer: data/address widths, opcode
// values and the FSM state encoding.
package cpu_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int CPU_ADDR_W = 4;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_LDI = 4'd8;
  localparam logic [3:0] OP_MOV = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

  // Opcodes above MOV are undefined.
  function automatic logic op_is_illegal(input logic [3:0] op);
    return op > OP_MOV;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU for the sequencer. carry is the ADD carry-out or the SUB
// borrow (a < b); it is zero for every other opcode.
module alu
  import cpu_pkg::*;
(
  input  logic [3:0]            op,
  input  logic [CPU_DATA_W-1:0] a,
  input  logic [CPU_DATA_W-1:0] b,
  input  logic [7:0]            imm8,
  output logic [CPU_DATA_W-1:0] result,
  output logic                  carry
);

  logic [CPU_DATA_W:0] sum_ext;
  logic [CPU_DATA_W:0] diff_ext;

  // One extra bit on each side captures the carry-out and the borrow.
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum_ext[CPU_DATA_W-1:0];
        carry  = sum_ext[CPU_DATA_W];
      end
      OP_SUB: begin
        result = diff_ext[CPU_DATA_W-1:0];
        carry  = diff_ext[CPU_DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = a << b[3:0];
      OP_SHR:  result = a >> b[3:0];
      OP_LDI:  result = {8'h00, imm8};
      OP_MOV:  result = a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Four-state instruction sequencer: accepts one instruction in IDLE, reads the
// register file, computes through the ALU and writes back the result.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instr,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] rf_read_addr_1,
  output logic [ADDR_W-1:0] rf_read_addr_2,
  input  logic [DATA_W-1:0] rf_read_data_1,
  input  logic [DATA_W-1:0] rf_read_data_2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic              flag_z,
  output logic              flag_c,
  output logic [1:0]        dbg_state
);

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both high; the source holds instr stable until then.

  state_t            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_c_q, flag_c_d;

  logic              we_c, done_c, illegal_c;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;

  assign opcode = instr_q[15:12];

  alu u_alu (
    .op     (opcode),
    .a      (rf_read_data_1),
    .b      (rf_read_data_2),
    .imm8   (instr_q[7:0]),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    result_d  = result_q;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    we_c      = 1'b0;
    done_c    = 1'b0;
    illegal_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (opcode == OP_NOP) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end else if (op_is_illegal(opcode)) begin
          illegal_c = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        // Operands are sampled here, so rd may alias rs1/rs2 safely.
        result_d = alu_result;
        flag_z_d = (alu_result == '0);
        flag_c_d = alu_carry;
        state_d  = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        we_c    = 1'b1;
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
    end
  end

  // Pulses are masked by rst so a reset during WRITEBACK drops the write.
  assign rf_we          = we_c & ~rst;
  assign done           = done_c & ~rst;
  assign illegal        = illegal_c & ~rst;
  assign instr_ready    = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign rf_read_addr_1 = instr_q[7:4];
  assign rf_read_addr_2 = instr_q[3:0];
  assign rf_write_addr  = instr_q[11:8];
  assign rf_write_data  = result_q;
  assign flag_z         = flag_z_q;
  assign flag_c         = flag_c_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer with a behavioural
// register file attached to its read/write ports.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic [3:0]  rf_read_addr_1, rf_read_addr_2;
  logic [15:0] rf_read_data_1, rf_read_data_2;
  logic        rf_we;
  logic [3:0]  rf_write_addr;
  logic [15:0] rf_write_data;
  logic        busy, done, illegal, flag_z, flag_c;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int we_count = 0;

  logic [15:0] rf [16];
  logic        tb_we = 1'b0;
  logic [3:0]  tb_addr = '0;
  logic [15:0] tb_data = '0;

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_ready    (instr_ready),
    .rf_read_addr_1 (rf_read_addr_1),
    .rf_read_addr_2 (rf_read_addr_2),
    .rf_read_data_1 (rf_read_data_1),
    .rf_read_data_2 (rf_read_data_2),
    .rf_we          (rf_we),
    .rf_write_addr  (rf_write_addr),
    .rf_write_data  (rf_write_data),
    .busy           (busy),
    .done           (done),
    .illegal        (illegal),
    .flag_z         (flag_z),
    .flag_c         (flag_c),
    .dbg_state      (dbg_state)
  );

  assign rf_read_data_1 = rf[rf_read_addr_1];
  assign rf_read_data_2 = rf[rf_read_addr_2];

  always @(posedge clk) begin
    if (rf_we) begin
      rf[rf_write_addr] <= rf_write_data;
      we_count <= we_count + 1;
    end else if (tb_we) begin
      rf[tb_addr] <= tb_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_reg(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Offers ins and returns 1 time unit after the accepting edge (DUT in DECODE).
  task automatic send(input logic [15:0] ins);
    int n;
    n = 0;
    @(negedge clk);
    instr = ins; instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", {31'b0, n < 20}, 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  // Accept cycle N: DECODE in N+1, EXECUTE in N+2, write in N+3, IDLE in N+4.
  task automatic run_write(input string tag, input logic [15:0] ins,
                           input logic [15:0] exp_data, input logic exp_z, input logic exp_c);
    send(ins);
    @(negedge clk);
    check({tag, "_dec_we"}, {31'b0, rf_we}, 32'd0);
    check({tag, "_dec_busy"}, {31'b0, busy}, 32'd1);
    @(negedge clk);
    check({tag, "_exe_we"}, {31'b0, rf_we}, 32'd0);
    @(negedge clk);
    check({tag, "_wb_we"}, {31'b0, rf_we}, 32'd1);
    check({tag, "_wb_done"}, {31'b0, done}, 32'd1);
    check({tag, "_wb_addr"}, {28'b0, rf_write_addr}, {28'b0, ins[11:8]});
    check({tag, "_wb_data"}, {16'b0, rf_write_data}, {16'b0, exp_data});
    check({tag, "_flag_z"}, {31'b0, flag_z}, {31'b0, exp_z});
    check({tag, "_flag_c"}, {31'b0, flag_c}, {31'b0, exp_c});
    @(negedge clk);
    check({tag, "_ready"}, {31'b0, instr_ready}, 32'd1);
    check({tag, "_rf"}, {16'b0, rf[ins[11:8]]}, {16'b0, exp_data});
  endtask

  initial begin
    int wc, low;
    for (int i = 0; i < 16; i++) rf[i] = '0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, instr_ready}, 32'd1);
    check("rst_we", {31'b0, rf_we}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_flags", {30'b0, flag_z, flag_c}, 32'd0);
    check("rst_wdata", {16'b0, rf_write_data}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    rst = 1'b0;

    // ADD r3 = r1 + r2 = 5 + 3
    load_reg(4'd1, 16'h0005);
    load_reg(4'd2, 16'h0003);
    run_write("add_basic", 16'h1312, 16'h0008, 1'b0, 1'b0);

    // ADD wrap: 0xFFFF + 1 -> 0, z=1, c=1
    load_reg(4'd1, 16'hFFFF);
    load_reg(4'd2, 16'h0001);
    run_write("add_wrap", 16'h1412, 16'h0000, 1'b1, 1'b1);

    // LDI r7 = 0xA5
    run_write("ldi", 16'h87A5, 16'h00A5, 1'b0, 1'b0);

    // SUB r8 = 2 - 5 -> 0xFFFD with borrow
    load_reg(4'd5, 16'h0002);
    load_reg(4'd6, 16'h0005);
    run_write("sub_borrow", 16'h2856, 16'hFFFD, 1'b0, 1'b1);

    // Illegal opcode 0xC: pulse, no write, flags (z=0,c=1) held
    wc = we_count;
    send(16'hC000);
    @(negedge clk);
    check("ill_pulse", {31'b0, illegal}, 32'd1);
    check("ill_done", {31'b0, done}, 32'd0);
    check("ill_we", {31'b0, rf_we}, 32'd0);
    @(negedge clk);
    check("ill_once", {31'b0, illegal}, 32'd0);
    check("ill_ready", {31'b0, instr_ready}, 32'd1);
    check("ill_flags", {30'b0, flag_z, flag_c}, 32'd1);
    check("ill_r7", {16'b0, rf[7]}, 32'h00A5);

    // NOP: done in DECODE, no write, flags held
    send(16'h0000);
    @(negedge clk);
    check("nop_done", {31'b0, done}, 32'd1);
    check("nop_we", {31'b0, rf_we}, 32'd0);
    @(negedge clk);
    check("nop_ready", {31'b0, instr_ready}, 32'd1);
    check("nop_flags", {30'b0, flag_z, flag_c}, 32'd1);
    check("nowrite_count", we_count, wc);

    // Logic and shift ops on 0x8421 and 0x0004
    load_reg(4'd11, 16'h8421);
    load_reg(4'd12, 16'h0004);
    run_write("shl", 16'h6DBC, 16'h4210, 1'b0, 1'b0);
    run_write("shr", 16'h7EBC, 16'h0842, 1'b0, 1'b0);
    run_write("and", 16'h3ABC, 16'h0000, 1'b1, 1'b0);
    run_write("or",  16'h4ABC, 16'h8425, 1'b0, 1'b0);
    run_write("xor", 16'h5FBC, 16'h8425, 1'b0, 1'b0);

    // rd aliases both sources: r1 = 0xFFFF + 0xFFFF
    run_write("add_alias", 16'h1111, 16'hFFFE, 1'b0, 1'b1);

    // Back-to-back with instr_valid held: LDI r7 then MOV r4 <- r7
    load_reg(4'd7, 16'h0000);
    @(negedge clk);
    instr = 16'h87A5; instr_valid = 1'b1;
    @(posedge clk);
    #1 instr = 16'h9470;
    low = 0;
    @(negedge clk);
    while (!instr_ready && low < 10) begin
      low++;
      @(negedge clk);
    end
    check("b2b_ready_low", low, 32'd3);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("b2b_r7", {16'b0, rf[7]}, 32'h00A5);
    check("b2b_r4", {16'b0, rf[4]}, 32'h00A5);
    check("b2b_idle", {31'b0, instr_ready}, 32'd1);

    // Make flags nonzero, then reset in EXECUTE
    run_write("add_c", 16'h1111, 16'hFFFC, 1'b0, 1'b1);
    wc = we_count;
    send(16'h1312);
    @(negedge clk);
    @(negedge clk);
    check("rst_exe_state", {30'b0, dbg_state}, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_exe_we", {31'b0, rf_we}, 32'd0);
    check("rst_exe_ready", {31'b0, instr_ready}, 32'd1);
    check("rst_exe_flags", {30'b0, flag_z, flag_c}, 32'd0);
    repeat (3) @(negedge clk);
    check("rst_exe_nowrite", we_count, wc);
    check("rst_exe_r3", {16'b0, rf[3]}, 32'h0008);

    // Reset during WRITEBACK drops the write
    send(16'h1912);
    repeat (3) @(negedge clk);
    check("rst_wb_state", {30'b0, dbg_state}, 32'd3);
    rst = 1'b1;
    #1 check("rst_wb_we_masked", {31'b0, rf_we}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wb_we", {31'b0, rf_we}, 32'd0);
    check("rst_wb_r9", {16'b0, rf[9]}, 32'h0000);
    check("rst_wb_nowrite", we_count, wc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
    $fatal(1, "watchdog");
  end

endmodule
